// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants for the inter-stage pipeline register:
//            state encoding, the default "no side effects" control value, and
//            per-boundary bundle widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy state of a pipe_stage_skid. 2'd3 is illegal and recovers to EMPTY.
  localparam logic [1:0] ST_EMPTY = 2'd0;  // no items held
  localparam logic [1:0] ST_ONE   = 2'd1;  // main entry valid
  localparam logic [1:0] ST_FULL  = 2'd2;  // main and skid entries valid

  // Control bundle value that encodes "no side effects" for every stage.
  localparam int          DEFAULT_CTRL_W      = 8;
  localparam logic [7:0]  DEFAULT_BUBBLE_CTRL = 8'h00;

  // Per-boundary bundle widths.
  localparam int IF_ID_DATA_W  = 96;   // instr + pc
  localparam int IF_ID_CTRL_W  = 2;
  localparam int ID_EX_DATA_W  = 224;  // pc + imm + rs1/rs2 operands
  localparam int ID_EX_CTRL_W  = 16;
  localparam int EX_MEM_DATA_W = 128;  // alu result + store data
  localparam int EX_MEM_CTRL_W = 8;
  localparam int MEM_WB_DATA_W = 64;   // writeback value
  localparam int MEM_WB_CTRL_W = 8;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
// Module   : pipe_entry
// Purpose  : One data+control register slot with load enable. Resets to
//            data=0, ctrl=BUBBLE_CTRL so an unloaded slot never carries side
//            effects.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            load_i          - capture data_i/ctrl_i this cycle
//            data_i, ctrl_i  - values to capture
//            data_o, ctrl_o  - registered contents
// Revision : 1.0 - initial release
// ============================================================================
module pipe_entry #(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= BUBBLE_CTRL;
    end else if (load_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule : pipe_entry
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Generic inter-stage pipeline register with valid/ready handshake
//            and a 2-entry (main + skid) buffer. in_ready is a pure decode of
//            the state register, so downstream backpressure never forms a
//            combinational path to upstream. Supports flush and a saturating
//            stall counter.
// Ports    : clk, rst                     - clock, sync active-high reset
//            in_valid/in_ready            - upstream handshake
//            in_data/in_ctrl              - upstream bundles
//            out_valid/out_ready          - downstream handshake
//            out_data/out_ctrl            - main entry contents
//            flush                        - drop held and incoming items
//            stall_cnt                    - cycles with in_valid & !in_ready
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              acc, xfer;
  logic              main_ld, skid_ld, main_from_skid;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);

  assign acc  = in_valid & in_ready;
  assign xfer = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_ONE;
          main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && xfer) begin
          main_ld = 1'b1;              // replace consumed item, stay ONE
        end else if (acc) begin
          state_d = ST_FULL;
          skid_ld = 1'b1;              // main still waiting, park in skid
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_d        = ST_ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops everything, including a concurrent accept; a concurrent
    // xfer was already taken by downstream so nothing more is needed.
    if (flush) begin
      state_d = ST_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  assign main_data_in = main_from_skid ? skid_data : in_data;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != CNT_MAX))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  pipe_entry #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_ld),
    .data_i (main_data_in),
    .ctrl_i (main_ctrl_in),
    .data_o (main_data),
    .ctrl_o (main_ctrl)
  );

  pipe_entry #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_ld),
    .data_i (in_data),
    .ctrl_i (in_ctrl),
    .data_o (skid_data),
    .ctrl_o (skid_ctrl)
  );

  assign out_data  = main_data;
  // The main ctrl register keeps stale contents after a drain or flush.
  assign out_ctrl  = out_valid ? main_ctrl : BUBBLE_CTRL;
  assign stall_cnt = stall_q;

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Directed self-checking bench for pipe_stage_skid. A second
//            instance with a 2-bit stall counter shares the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [63:0] out_data, out_data2;
  logic [7:0]  out_ctrl, out_ctrl2;
  logic        flush;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .out_ctrl  (out_ctrl2),
    .flush     (flush),
    .stall_cnt (stall_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before any check.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = 8'h80 | d[7:0];
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF;
    in_ctrl  = 8'h5A;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] d);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_ctrl"},  {56'd0, out_ctrl}, {56'd0, 8'h80 | d[7:0]});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_ctrl"},  {56'd0, out_ctrl}, 64'd0);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle_in();

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_empty("reset");
    chk("reset_data",  out_data, 64'd0);
    chk("reset_stall", {48'd0, stall_cnt}, 64'd0);

    // Streaming: each item one cycle later, no gaps, never FULL
    out_ready = 1'b1;
    push(64'h11); tick();
    chk_out("s11", 64'h11); chk("s11_rdy", {63'd0, in_ready}, 64'd1);
    push(64'h22); tick();
    chk_out("s22", 64'h22); chk("s22_rdy", {63'd0, in_ready}, 64'd1);
    push(64'h33); tick();
    chk_out("s33", 64'h33); chk("s33_rdy", {63'd0, in_ready}, 64'd1);
    idle_in(); tick();
    chk_empty("s_drain");
    chk("s_stall", {48'd0, stall_cnt}, 64'd0);

    // Backpressure: fill, stall 3 cycles, then drain in order
    out_ready = 1'b0;
    push(64'hA); tick();
    chk_out("bpA", 64'hA); chk("bpA_rdy", {63'd0, in_ready}, 64'd1);
    push(64'hB); tick();
    chk_out("bpB_main", 64'hA); chk("bp_full_rdy", {63'd0, in_ready}, 64'd0);
    push(64'hC);
    tick(); tick(); tick();
    chk_out("bp_hold", 64'hA);
    chk("bp_stall3", {48'd0, stall_cnt}, 64'd3);
    chk("bp_stall3_sat", {62'd0, stall_cnt2}, 64'd3);
    out_ready = 1'b1;            // in_ready still 0 this cycle: one more stall
    tick();
    chk_out("bp_outB", 64'hB);
    chk("bp_stall4", {48'd0, stall_cnt}, 64'd4);
    chk("bp_one_rdy", {63'd0, in_ready}, 64'd1);
    tick();                      // C accepted while B leaves
    chk_out("bp_outC", 64'hC);
    idle_in(); tick();
    chk_empty("bp_drain");
    chk("bp_stall_keep", {48'd0, stall_cnt}, 64'd4);

    // Flush in FULL with stalled input
    out_ready = 1'b0;
    push(64'hA); tick();
    push(64'hB); tick();
    push(64'hC); flush = 1'b1;
    #1;
    chk("fl_ready_pre", {63'd0, in_ready}, 64'd0);
    tick();                      // flush cycle also counts as a stall
    flush = 1'b0; idle_in();
    chk_empty("fl_next");
    chk("fl_stall", {48'd0, stall_cnt}, 64'd5);
    out_ready = 1'b1;
    tick();
    chk("fl_gone1", {63'd0, out_valid}, 64'd0);
    tick();
    chk("fl_gone2", {63'd0, out_valid}, 64'd0);

    // Simultaneous accept and transfer in ONE
    out_ready = 1'b0;
    push(64'h5); tick();
    chk_out("sim5", 64'h5);
    out_ready = 1'b1;
    push(64'h6); tick();
    chk_out("sim6", 64'h6);
    chk("sim6_rdy", {63'd0, in_ready}, 64'd1);
    idle_in(); tick();
    chk_empty("sim_drain");

    // Reset mid-operation from FULL with stalled input
    out_ready = 1'b0;
    push(64'h77); tick();
    push(64'h88); tick();
    push(64'h99); tick();
    chk("rm_full", {63'd0, in_ready}, 64'd0);
    rst = 1'b1; tick();
    rst = 1'b0; idle_in();
    chk_empty("rm");
    chk("rm_data",  out_data, 64'd0);
    chk("rm_stall", {48'd0, stall_cnt}, 64'd0);
    tick();
    chk("rm_still_empty", {63'd0, out_valid}, 64'd0);

    // Counter saturation on the 2-bit instance
    push(64'h41); tick();
    push(64'h42); tick();
    push(64'h43);
    tick(); tick(); tick();
    chk("sat_3",  {62'd0, stall_cnt2}, 64'd3);
    tick(); tick(); tick();
    chk("sat_6",  {62'd0, stall_cnt2}, 64'd3);
    chk("wide_6", {48'd0, stall_cnt}, 64'd6);
    chk_out("sat_head", 64'h41);
    rst = 1'b1; tick();
    rst = 1'b0; idle_in();
    chk("sat_rst", {62'd0, stall_cnt2}, 64'd0);
    chk("wide_rst", {48'd0, stall_cnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_stage_skid
`default_nettype wire
